// File: rtl/pool_pkg.sv
// Shared helpers for the pooling stage: window packing index and sizing functions.
// The window generator and the Maxpool side both import this package.
package pool_pkg;

  function automatic int cnt_width(input int bound);
    return (bound <= 1) ? 1 : $clog2(bound);
  endfunction

  function automatic int win_width(input int stride, input int data_width);
    return stride * stride * data_width;
  endfunction

  function automatic int windows_per(input int size, input int stride);
    return size / stride;
  endfunction

  // Element (r,k) of a window: r = row within window (0 = top), k = column (0 = left).
  function automatic int elem_idx(input int r, input int k, input int stride);
    return r * stride + k;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Line buffer of STRIDE_SIZE-1 image rows, one write port, and a read port per stored
// row returning the STRIDE_SIZE-pixel column span ending at col.
module pool_line_buffer
  import pool_pkg::*;
#(
  parameter int STRIDE_SIZE = 2,
  parameter int DATA_WIDTH  = 16,
  parameter int COLUMN_SIZE = 4,
  localparam int CW = cnt_width(COLUMN_SIZE),
  localparam int PW = cnt_width(STRIDE_SIZE)
) (
  input  logic                                                  clock,
  input  logic                                                  wr_en,
  input  logic [PW-1:0]                                         wr_row,
  input  logic [CW-1:0]                                         col,
  input  logic [DATA_WIDTH-1:0]                                 wr_data,
  output logic [STRIDE_SIZE-2:0][STRIDE_SIZE-1:0][DATA_WIDTH-1:0] rd_data
);

  localparam int S = STRIDE_SIZE;

  logic [S-1:0][CW-1:0] rd_idx;

  // Span index k maps to column col-(S-1)+k; the clamp only matters when no window is emitted.
  for (genvar k = 0; k < S; k++) begin : g_idx
    if (k == S - 1) begin : g_cur
      assign rd_idx[k] = col;
    end else begin : g_prev
      assign rd_idx[k] = (col >= CW'(S - 1 - k)) ? col - CW'(S - 1 - k) : '0;
    end
  end

  for (genvar r = 0; r < S - 1; r++) begin : g_row
    logic [DATA_WIDTH-1:0] mem [COLUMN_SIZE];

    always_ff @(posedge clock) begin
      if (wr_en && (wr_row == PW'(r))) begin
        mem[col] <= wr_data;
      end
    end

    for (genvar k = 0; k < S; k++) begin : g_rd
      assign rd_data[r][k] = mem[rd_idx[k]];
    end
  end

endmodule

// File: rtl/pool_window_gen.sv
// Pooling front end: raster pixel stream in, one packed non-overlapping
// STRIDE_SIZE x STRIDE_SIZE window out per completed window, one cycle after its last pixel.
module pool_window_gen
  import pool_pkg::*;
#(
  parameter int STRIDE_SIZE = 2,
  parameter int DATA_WIDTH  = 16,
  parameter int ROW_SIZE    = 4,
  parameter int COLUMN_SIZE = 4
) (
  input  logic                                            clock,
  input  logic                                            sreset_n,
  input  logic [DATA_WIDTH-1:0]                           pixel_in,
  input  logic                                            pixel_in_valid,
  output logic [win_width(STRIDE_SIZE, DATA_WIDTH)-1:0]   window_out,
  output logic                                            window_valid,
  output logic                                            frame_done
);

  localparam int S       = STRIDE_SIZE;
  localparam int DW      = DATA_WIDTH;
  localparam int WW      = win_width(S, DW);
  localparam int RW      = cnt_width(ROW_SIZE);
  localparam int CW      = cnt_width(COLUMN_SIZE);
  localparam int PW      = cnt_width(S);
  localparam int ROW_LIM = windows_per(ROW_SIZE, S) * S;
  localparam int COL_LIM = windows_per(COLUMN_SIZE, S) * S;

  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [PW-1:0] row_ph;
  logic [PW-1:0] col_ph;
  logic          last_col;
  logic          last_row;
  logic          row_in;
  logic          col_in;
  logic          emit;

  logic [S-2:0][DW-1:0]        row_sr;
  logic [S-2:0][DW-1:0]        sr_next;
  logic [S-2:0][S-1:0][DW-1:0] lb_data;
  logic [WW-1:0]               window_next;

  assign last_col = (col == CW'(COLUMN_SIZE - 1));
  assign last_row = (row == RW'(ROW_SIZE - 1));

  // Trailing rows/columns that cannot fill a whole window are never emitted.
  if (ROW_LIM == ROW_SIZE) begin : g_row_all
    assign row_in = 1'b1;
  end else begin : g_row_lim
    assign row_in = (row < RW'(ROW_LIM));
  end

  if (COL_LIM == COLUMN_SIZE) begin : g_col_all
    assign col_in = 1'b1;
  end else begin : g_col_lim
    assign col_in = (col < CW'(COL_LIM));
  end

  assign emit = pixel_in_valid && (row_ph == PW'(S - 1)) && (col_ph == PW'(S - 1))
                && row_in && col_in;

  always_ff @(posedge clock) begin
    if (!sreset_n) begin
      row    <= '0;
      col    <= '0;
      row_ph <= '0;
      col_ph <= '0;
    end else if (pixel_in_valid) begin
      if (last_col) begin
        col    <= '0;
        col_ph <= '0;
        row    <= last_row ? '0 : row + RW'(1);
        row_ph <= (last_row || (row_ph == PW'(S - 1))) ? '0 : row_ph + PW'(1);
      end else begin
        col    <= col + CW'(1);
        col_ph <= (col_ph == PW'(S - 1)) ? '0 : col_ph + PW'(1);
      end
    end
  end

  // Shift register of the previous S-1 pixels in the current row; index 0 is the newest.
  assign sr_next[0] = pixel_in;
  for (genvar i = 1; i < S - 1; i++) begin : g_sr
    assign sr_next[i] = row_sr[i-1];
  end

  always_ff @(posedge clock) begin
    if (pixel_in_valid) begin
      row_sr <= sr_next;
    end
  end

  pool_line_buffer #(
    .STRIDE_SIZE (S),
    .DATA_WIDTH  (DW),
    .COLUMN_SIZE (COLUMN_SIZE)
  ) u_line_buffer (
    .clock   (clock),
    .wr_en   (sreset_n && pixel_in_valid && (row_ph != PW'(S - 1))),
    .wr_row  (row_ph),
    .col     (col),
    .wr_data (pixel_in),
    .rd_data (lb_data)
  );

  for (genvar r = 0; r < S - 1; r++) begin : g_win_top
    for (genvar k = 0; k < S; k++) begin : g_k
      assign window_next[elem_idx(r, k, S)*DW +: DW] = lb_data[r][k];
    end
  end

  for (genvar k = 0; k < S - 1; k++) begin : g_win_bot
    assign window_next[elem_idx(S - 1, k, S)*DW +: DW] = row_sr[S-2-k];
  end

  // The bottom-right element bypasses storage so the window leaves one cycle after it arrives.
  assign window_next[elem_idx(S - 1, S - 1, S)*DW +: DW] = pixel_in;

  always_ff @(posedge clock) begin
    if (!sreset_n) begin
      window_out   <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      window_valid <= emit;
      frame_done   <= pixel_in_valid && last_row && last_col;
      if (emit) begin
        window_out <= window_next;
      end
    end
  end

endmodule

// File: tb/tb_pool_window_gen.sv
// Scoreboard bench for pool_window_gen: three instances (2/4x4, 2/5x5, 3/6x6) driven one at a time.
module tb_pool_window_gen;

  localparam int NI = 3;
  localparam int XW = 144;

  logic          clk;
  logic [NI-1:0] rstn;
  logic [NI-1:0] vld;
  logic [15:0]   pix [NI];
  logic [XW-1:0] wout [NI];
  logic [NI-1:0] wvalid;
  logic [NI-1:0] fdone;

  logic [NI-1:0] in_emit;
  logic [NI-1:0] in_last;
  logic [NI-1:0] exp_wv;
  logic [NI-1:0] exp_fd;
  logic [NI-1:0] rst_seen;
  logic [XW-1:0] last_w [NI];
  logic [XW-1:0] exp_q [$];
  logic [XW-1:0] popped;
  bit            mon_en;

  int n_checks;
  int n_errors;

  function automatic int cfg_s(input int g);
    return (g == 2) ? 3 : 2;
  endfunction

  function automatic int cfg_n(input int g);
    return (g == 0) ? 4 : ((g == 1) ? 5 : 6);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int S = (g == 2) ? 3 : 2;
    localparam int N = (g == 0) ? 4 : ((g == 1) ? 5 : 6);
    logic [S*S*16-1:0] w;

    pool_window_gen #(
      .STRIDE_SIZE (S),
      .DATA_WIDTH  (16),
      .ROW_SIZE    (N),
      .COLUMN_SIZE (N)
    ) u_dut (
      .clock          (clk),
      .sreset_n       (rstn[g]),
      .pixel_in       (pix[g]),
      .pixel_in_valid (vld[g]),
      .window_out     (w),
      .window_valid   (wvalid[g]),
      .frame_done     (fdone[g])
    );

    assign wout[g] = XW'(w);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [XW-1:0] got, input logic [XW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Timing reference for the valid/frame_done strobes, including reset priority.
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      exp_wv[g]   <= rstn[g] & vld[g] & in_emit[g];
      exp_fd[g]   <= rstn[g] & vld[g] & in_last[g];
      rst_seen[g] <= ~rstn[g];
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      for (int g = 0; g < NI; g++) begin
        if (rst_seen[g]) last_w[g] = '0;
        check_val($sformatf("valid_i%0d", g), XW'(wvalid[g]), XW'(exp_wv[g]));
        check_val($sformatf("frame_done_i%0d", g), XW'(fdone[g]), XW'(exp_fd[g]));
        if (wvalid[g]) begin
          if (exp_q.size() == 0) begin
            check_val($sformatf("queue_size_i%0d", g), XW'(exp_q.size()), XW'(1));
          end else begin
            popped = exp_q.pop_front();
            check_val($sformatf("window_i%0d", g), wout[g], popped);
            last_w[g] = popped;
          end
        end else begin
          check_val($sformatf("hold_i%0d", g), wout[g], last_w[g]);
        end
      end
    end
  end

  task automatic send(input int g, input int base, input int r, input int c);
    int s;
    int n;
    logic [XW-1:0] w;
    s = cfg_s(g);
    n = cfg_n(g);
    @(posedge clk);
    #1;
    pix[g]     = 16'(base + r*n + c + 1);
    vld[g]     = 1'b1;
    in_last[g] = (r == n-1) && (c == n-1);
    in_emit[g] = (r % s == s-1) && (c % s == s-1) && (r < (n/s)*s) && (c < (n/s)*s);
    if (in_emit[g]) begin
      w = '0;
      for (int i = 0; i < s; i++)
        for (int j = 0; j < s; j++)
          w[(i*s + j)*16 +: 16] = 16'(base + (r - s + 1 + i)*n + (c - s + 1 + j) + 1);
      exp_q.push_back(w);
    end
  endtask

  task automatic idle(input int g);
    @(posedge clk);
    #1;
    vld[g]     = 1'b0;
    pix[g]     = 16'($urandom);
    in_emit[g] = 1'b0;
    in_last[g] = 1'b0;
  endtask

  task automatic frame(input int g, input int base, input bit gap, input int npix);
    int n;
    n = cfg_n(g);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        if (r*n + c < npix) begin
          send(g, base, r, c);
          if (gap) idle(g);
        end
  endtask

  // Reset with a valid pixel on the same edge: reset must win.
  task automatic do_reset(input int g);
    @(posedge clk);
    #1;
    rstn[g]    = 1'b0;
    vld[g]     = 1'b1;
    pix[g]     = 16'hBEEF;
    in_emit[g] = 1'b0;
    in_last[g] = 1'b0;
    @(posedge clk);
    #1;
    rstn[g] = 1'b1;
    vld[g]  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    mon_en   = 1'b0;
    rstn     = '0;
    vld      = '0;
    in_emit  = '0;
    in_last  = '0;
    for (int g = 0; g < NI; g++) begin
      pix[g]    = '0;
      last_w[g] = '0;
    end
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    rstn = '1;

    frame(0, 0, 1'b0, 16);
    repeat (3) idle(0);
    frame(0, 0, 1'b1, 16);
    repeat (3) idle(0);
    frame(0, 0, 1'b0, 16);
    frame(0, 100, 1'b0, 16);
    repeat (3) idle(0);
    frame(0, 0, 1'b0, 7);
    do_reset(0);
    idle(0);
    frame(0, 0, 1'b0, 16);
    repeat (3) idle(0);

    frame(1, 0, 1'b0, 25);
    repeat (3) idle(1);

    frame(2, 0, 1'b0, 36);
    repeat (4) idle(2);

    check_val("queue_left", XW'(exp_q.size()), XW'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pool_window_gen.md
Name: pool_window_gen

Overview:
- Front end of the pooling stage. Takes one fixed-point pixel per valid cycle in raster order.
- Buffers STRIDE_SIZE-1 previous image rows and emits each non-overlapping STRIDE_SIZE×STRIDE_SIZE window as one packed word, with a one-cycle valid strobe.
- Output port matches the Maxpool data_in/data_in_valid interface exactly, so the two instantiate back-to-back.
- Streaming only: no backpressure, since the downstream pool stage always accepts.

Parameters:
- STRIDE_SIZE, 2, pooling window edge and stride (non-overlapping); ≥2.
- DATA_WIDTH, 16, pixel width in bits; fixed-point contents are passed through untouched.
- ROW_SIZE, 4, image rows per frame.
- COLUMN_SIZE, 4, pixels per image row.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- sreset_n  in  1  synchronous, active-low reset.
- pixel_in  in  DATA_WIDTH  input pixel, raster order (row-major).
- pixel_in_valid  in  1  pixel_in is accepted on every rising edge where this is high.
- window_out  out  STRIDE_SIZE*STRIDE_SIZE*DATA_WIDTH  packed window for Maxpool data_in.
- window_valid  out  1  one-cycle strobe; window_out is valid.
- frame_done  out  1  one-cycle strobe on the cycle after the frame's last pixel is accepted.

Behaviour:
- Reset (sreset_n=0 at a clock edge):
  - window_out, window_valid, frame_done all 0.
  - Row and column counters cleared to 0.
  - Line buffer contents are don't-care; no output may depend on them before they are rewritten.
- Counters:
  - col advances 0..COLUMN_SIZE-1 on each accepted pixel.
  - row advances when col wraps, 0..ROW_SIZE-1.
  - Both wrap to 0 after the last pixel of a frame, so the next frame follows with zero idle cycles.
- Storage:
  - Line buffer holds STRIDE_SIZE-1 rows × COLUMN_SIZE pixels, addressed by (row mod STRIDE_SIZE, col).
  - A row-local shift register holds the previous STRIDE_SIZE-1 pixels of the current row.
- Window emission condition:
  - Pixel accepted with (row mod S)==S-1, (col mod S)==S-1, row < (ROW_SIZE/S)*S and col < (COLUMN_SIZE/S)*S (integer division).
  - On the next edge, window_valid=1 and window_out is loaded. Latency is exactly 1 cycle after acceptance.
- Packing:
  - Window element (r,k), with r = row within window (0=top) and k = column within window (0=left), occupies bits [(r*S+k)*DATA_WIDTH +: DATA_WIDTH].
  - Element (S-1,S-1) is the triggering pixel itself, taken directly from pixel_in (bypass), not from storage.
- Partial windows:
  - Trailing columns/rows beyond a multiple of S are accepted and counted but never emitted (floor pooling).
  - A window counts as emitted only when window_valid is high.
- Gaps: pixel_in_valid low freezes all state. window_valid and frame_done drop to 0. window_out holds its last value.
- frame_done: pulses 1 cycle after the pixel at (ROW_SIZE-1, COLUMN_SIZE-1) is accepted. It may coincide with the last window_valid.
- Reset mid-frame: takes priority over pixel_in_valid on the same edge. The frame is abandoned; the next accepted pixel is (0,0).
- Arithmetic: none on data. Counter widths are $clog2 of their bound, minimum 1 bit.

Decomposition:
- Shared package pool_pkg:
  - Function for the packed element index, (r*S+k).
  - Localparam helpers: window word width, counter widths, and emitted windows per row/column.
  - The Maxpool side uses the same package.
- One sub-module, pool_line_buffer:
  - Register/RAM array of (S-1)×COLUMN_SIZE pixels.
  - One write port (current pixel at col, when row mod S < S-1).
  - S-1 read ports for the column span [col-S+1 .. col].
- Top level keeps the counters, the row shift register and the output register.

Test Plan:
- 4×4, S=2, pixels 1..16 on contiguous valid cycles → four window_valid pulses, one cycle after pixels 6, 8, 14, 16:
  - Windows {1,2,5,6}, {3,4,7,8}, {9,10,13,14}, {11,12,15,16}, with element index 0 = top-left.
  - frame_done pulses with the last window.
- Same frame with pixel_in_valid low on every other cycle → identical windows in the same order.
  - window_valid is never high on consecutive cycles.
  - window_out is stable between pulses.
- Two frames back-to-back (1..16 then 101..116) → 8 windows; the second frame's first window is {101,102,105,106}.
  - No stale first-frame data appears in the second frame.
- Reset asserted after pixel 7, then a full 1..16 frame → no window before re-fill; exactly the four windows of the first scenario.
- ROW_SIZE=5, COLUMN_SIZE=5, pixels 1..25 → only {1,2,6,7}, {3,4,8,9}, {11,12,16,17}, {13,14,18,19}.
  - frame_done pulses after pixel 25.
- S=3, 6×6, pixels 1..36 → four windows; the first is {1,2,3,7,8,9,13,14,15} and the last is {22,23,24,28,29,30,34,35,36}.
